// File: rtl/sm_mon_pkg.sv
// Shared state encoding and helpers for the FSM output monitor.
package sm_mon_pkg;

    localparam int ST_W = 2;  // state register width
    localparam int RC_W = 4;  // run / clean counter width

    typedef enum logic [ST_W-1:0] {
        ST_OK    = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    // Saturating +1 for the run/clean trackers.
    function automatic logic [RC_W-1:0] sat_inc_rc(input logic [RC_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with optional rising-edge qualification and
// synchronous clear. The previous-value register keeps tracking the input
// through a clear so an input held high is not recounted afterwards.
module sat_event_counter #(
    parameter int W    = 8,
    parameter bit EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         sample,
    output logic [W-1:0] count
);

    logic prev;
    logic hit;

    // Event qualifier: rising edge of the sample, or simply the sample level.
    assign hit = EDGE ? (sample & ~prev) : sample;

    // Previous-value tracking and saturating count; clear beats an increment.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            count <= '0;
        end else begin
            prev <= sample;
            if (clr) begin
                count <= '0;
            end else if (hit && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_output_monitor.sv
// Health monitor for the upstream FSM outputs: counts o1/o2 rising edges and
// err cycles, and escalates sustained err runs OK -> WARN -> sticky ALARM.
module sm_output_monitor
    import sm_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 3,
    parameter int RECOVER    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             o1_in,
    input  logic             o2_in,
    input  logic             err_in,
    input  logic             clr,
    output logic [CNT_W-1:0] o1_cnt,
    output logic [CNT_W-1:0] o2_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             warn,
    output logic             alarm
);

    localparam logic [RC_W-1:0] THRESH_C  = RC_W'(ERR_THRESH);
    localparam logic [RC_W-1:0] RECOVER_C = RC_W'(RECOVER);

    state_t          state, state_n;
    logic [RC_W-1:0] run, run_n;
    logic [RC_W-1:0] clean, clean_n;
    logic [RC_W-1:0] run_inc, clean_inc;

    sat_event_counter #(.W(CNT_W), .EDGE(1'b1)) u_o1_cnt (
        .clk(clk), .rst(rst), .clr(clr), .sample(o1_in), .count(o1_cnt)
    );

    sat_event_counter #(.W(CNT_W), .EDGE(1'b1)) u_o2_cnt (
        .clk(clk), .rst(rst), .clr(clr), .sample(o2_in), .count(o2_cnt)
    );

    sat_event_counter #(.W(CNT_W), .EDGE(1'b0)) u_err_cnt (
        .clk(clk), .rst(rst), .clr(clr), .sample(err_in), .count(err_cnt)
    );

    assign run_inc   = sat_inc_rc(run);
    assign clean_inc = sat_inc_rc(clean);

    // State, run and clean registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OK;
            run   <= '0;
            clean <= '0;
        end else begin
            state <= state_n;
            run   <= run_n;
            clean <= clean_n;
        end
    end

    // Next-state logic: escalate on err runs, recover on clean runs,
    // leave ALARM only on an acknowledged clear with err low.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n = state;
        run_n   = run;
        clean_n = clean;
        case (state)
            ST_OK: begin
                if (err_in) begin
                    state_n = ST_WARN;
                    run_n   = 4'd1;
                    clean_n = '0;
                end
            end
            ST_WARN: begin
                if (err_in) begin
                    run_n   = run_inc;
                    clean_n = '0;
                    if (run_inc == THRESH_C) state_n = ST_ALARM;
                end else begin
                    run_n   = '0;
                    clean_n = clean_inc;
                    if (clean_inc == RECOVER_C) state_n = ST_OK;
                end
            end
            ST_ALARM: begin
                if (clr && !err_in) begin
                    state_n = ST_OK;
                    run_n   = '0;
                    clean_n = '0;
                end
            end
            default: begin
                state_n = ST_OK;
                run_n   = '0;
                clean_n = '0;
            end
        endcase
    end

    // Registered one-hot decode of the next state; warn and alarm are exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn  <= 1'b0;
            alarm <= 1'b0;
        end else begin
            warn  <= (state_n == ST_WARN);
            alarm <= (state_n == ST_ALARM);
        end
    end

endmodule

// File: tb/tb_sm_output_monitor.sv
// Directed bench for sm_output_monitor: a default instance plus a CNT_W=3
// instance for the saturation scenario, both driven from the same inputs.
module tb_sm_output_monitor;

    logic       clk;
    logic       rst;
    logic       o1_in;
    logic       o2_in;
    logic       err_in;
    logic       clr;
    logic [7:0] o1_cnt, o2_cnt, err_cnt;
    logic       warn, alarm;
    logic [2:0] s_o1_cnt, s_o2_cnt, s_err_cnt;
    logic       s_warn, s_alarm;

    int checks = 0;
    int errors = 0;

    sm_output_monitor dut (
        .clk(clk), .rst(rst), .o1_in(o1_in), .o2_in(o2_in), .err_in(err_in),
        .clr(clr), .o1_cnt(o1_cnt), .o2_cnt(o2_cnt), .err_cnt(err_cnt),
        .warn(warn), .alarm(alarm)
    );

    sm_output_monitor #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .o1_in(o1_in), .o2_in(o2_in), .err_in(err_in),
        .clr(clr), .o1_cnt(s_o1_cnt), .o2_cnt(s_o2_cnt), .err_cnt(s_err_cnt),
        .warn(s_warn), .alarm(s_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; o1_in = 1'b0; o2_in = 1'b0; err_in = 1'b0; clr = 1'b0;
        step();
        step();
        checks++;
        if ({o1_cnt, o2_cnt, err_cnt, warn, alarm} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got o1=%0d o2=%0d err=%0d warn=%b alarm=%b exp all 0",
                     o1_cnt, o2_cnt, err_cnt, warn, alarm);
        end
        checks++;
        if ({s_o1_cnt, s_o2_cnt, s_err_cnt, s_warn, s_alarm} !== 11'd0) begin
            errors++;
            $display("FAIL reset_small got o2=%0d warn=%b alarm=%b exp all 0",
                     s_o2_cnt, s_warn, s_alarm);
        end
        rst = 1'b0;
    endtask

    task automatic test_o1_edges();
        for (int i = 0; i < 3; i++) begin
            o1_in = 1'b1; step();
            o1_in = 1'b0; step();
            step();
        end
        checks++;
        if (o1_cnt !== 8'd3) begin
            errors++;
            $display("FAIL o1_pulses got %0d exp 3", o1_cnt);
        end
        checks++;
        if (o2_cnt !== 8'd0) begin
            errors++;
            $display("FAIL o2_idle got %0d exp 0", o2_cnt);
        end
        o1_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        o1_in = 1'b0;
        checks++;
        if (o1_cnt !== 8'd4) begin
            errors++;
            $display("FAIL o1_held got %0d exp 4", o1_cnt);
        end
    endtask

    task automatic test_alarm_escalation();
        logic [2:0] exp_warn  = 3'b011;  // bit i = expected after edge i
        logic [2:0] exp_alarm = 3'b100;
        err_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (warn !== exp_warn[i] || alarm !== exp_alarm[i]) begin
                errors++;
                $display("FAIL escalate_edge%0d got warn=%b alarm=%b exp warn=%b alarm=%b",
                         i, warn, alarm, exp_warn[i], exp_alarm[i]);
            end
        end
        err_in = 1'b0;
        checks++;
        if (err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL err_cnt_run got %0d exp 3", err_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (alarm !== 1'b1 || warn !== 1'b0) begin
                errors++;
                $display("FAIL alarm_sticky cycle %0d got alarm=%b warn=%b exp 1/0", i, alarm, warn);
            end
        end
    endtask

    task automatic test_alarm_clear();
        clr = 1'b1; err_in = 1'b1;
        step();
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_err_alarm got %b exp 1", alarm);
        end
        checks++;
        if ({o1_cnt, o2_cnt, err_cnt} !== 24'd0) begin
            errors++;
            $display("FAIL clr_counters got o1=%0d o2=%0d err=%0d exp 0", o1_cnt, o2_cnt, err_cnt);
        end
        err_in = 1'b0;
        step();
        clr = 1'b0;
        checks++;
        if (alarm !== 1'b0 || warn !== 1'b0) begin
            errors++;
            $display("FAIL clr_ack got alarm=%b warn=%b exp 0/0", alarm, warn);
        end
        step();
        checks++;
        if (alarm !== 1'b0 || warn !== 1'b0) begin
            errors++;
            $display("FAIL post_ack got alarm=%b warn=%b exp 0/0", alarm, warn);
        end
    endtask

    task automatic test_recovery();
        logic [6:0] pat       = 7'b0011011;  // bit i applied at edge i: 1,1,0,1,1,0,0
        logic [6:0] exp_warn  = 7'b0111111;
        for (int i = 0; i < 7; i++) begin
            err_in = pat[i];
            step();
            checks++;
            if (warn !== exp_warn[i] || alarm !== 1'b0) begin
                errors++;
                $display("FAIL recover_edge%0d got warn=%b alarm=%b exp warn=%b alarm=0",
                         i, warn, alarm, exp_warn[i]);
            end
        end
        err_in = 1'b0;
        checks++;
        if (err_cnt !== 8'd4) begin
            errors++;
            $display("FAIL recover_err_cnt got %0d exp 4", err_cnt);
        end
    endtask

    task automatic test_saturation();
        o2_in = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            o2_in = 1'b1; step();
            o2_in = 1'b0; step();
        end
        checks++;
        if (s_o2_cnt !== 3'd7) begin
            errors++;
            $display("FAIL o2_saturate got %0d exp 7", s_o2_cnt);
        end
        checks++;
        if (o2_cnt !== 8'd10) begin
            errors++;
            $display("FAIL o2_wide got %0d exp 10", o2_cnt);
        end
        o2_in = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (s_o2_cnt !== 3'd0 || o2_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_beats_edge got small=%0d wide=%0d exp 0", s_o2_cnt, o2_cnt);
        end
        step();
        checks++;
        if (s_o2_cnt !== 3'd0) begin
            errors++;
            $display("FAIL held_after_clr got %0d exp 0", s_o2_cnt);
        end
        o2_in = 1'b0;
    endtask

    task automatic test_reset_mid_warn();
        err_in = 1'b1;
        step();
        step();
        checks++;
        if (warn !== 1'b1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL mid_warn got warn=%b alarm=%b exp 1/0", warn, alarm);
        end
        rst = 1'b1; o1_in = 1'b1;
        step();
        checks++;
        if ({o1_cnt, o2_cnt, err_cnt, warn, alarm} !== 26'd0) begin
            errors++;
            $display("FAIL rst_wins got o1=%0d o2=%0d err=%0d warn=%b alarm=%b exp all 0",
                     o1_cnt, o2_cnt, err_cnt, warn, alarm);
        end
        rst = 1'b0; err_in = 1'b0;
        step();
        checks++;
        if (o1_cnt !== 8'd1 || warn !== 1'b0) begin
            errors++;
            $display("FAIL first_edge_after_rst got o1=%0d warn=%b exp 1/0", o1_cnt, warn);
        end
        o1_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_o1_edges();
        test_alarm_escalation();
        test_alarm_clear();
        test_recovery();
        test_saturation();
        test_reset_mid_warn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
